// File: rtl/worm_race_ctrl.sv
// Round-robin arbiter and saturating position updater for the worm race datapath.
// One move is granted per cycle while racing; the first forward move onto MAXPOS ends the race.
module worm_race_ctrl #(
  parameter int NW     = 4,
  parameter int MAXPOS = 15
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [NW-1:0]   req,
  input  logic [2*NW-1:0] steps,
  input  logic [NW-1:0]   dir,
  output logic [NW-1:0]   gnt,
  output logic [5*NW-1:0] pos,
  output logic            running,
  output logic            winner_vld,
  output logic [1:0]      winner_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WIN  = 2'd2;

  localparam logic [5:0] MAX6 = 6'(MAXPOS);

  logic [1:0]    r_state;
  logic [1:0]    r_ptr;
  logic [NW-1:0] r_gnt;
  logic [4:0]    r_pos [NW];
  logic          r_winner_vld;
  logic [1:0]    r_winner_id;

  logic          w_hi_any;
  logic [1:0]    w_hi_idx;
  logic          w_lo_any;
  logic [1:0]    w_lo_idx;
  logic          w_any;
  logic [1:0]    w_idx;
  logic [1:0]    w_nxt;
  logic [1:0]    w_step;
  logic          w_dir;
  logic [5:0]    w_cur;
  logic [5:0]    w_sum;
  logic [4:0]    w_new;
  logic          w_win;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_any = 1'b0;
    w_lo_idx = '0;
    for (int j = NW - 1; j >= 0; j--) begin
      if (req[j]) begin
        w_lo_any = 1'b1;
        w_lo_idx = 2'(j);
        if (2'(j) >= r_ptr) begin
          w_hi_any = 1'b1;
          w_hi_idx = 2'(j);
        end
      end
    end
  end

  assign w_any = w_lo_any;
  assign w_idx = w_hi_any ? w_hi_idx : w_lo_idx;
  assign w_nxt = (w_idx == 2'(NW - 1)) ? 2'd0 : w_idx + 2'd1;

  always_comb begin
    w_step = '0;
    w_dir  = 1'b0;
    for (int j = 0; j < NW; j++) begin
      if (w_idx == 2'(j)) begin
        w_step = steps[2*j +: 2];
        w_dir  = dir[j];
      end
    end
  end

  assign w_cur = {1'b0, r_pos[w_idx]};
  assign w_sum = w_cur + {4'b0, w_step};

  // Forward saturates at the finish line and reaching it is the win; backward floors at zero.
  always_comb begin
    w_new = '0;
    w_win = 1'b0;
    if (w_dir) begin
      if ({4'b0, w_step} > w_cur) w_new = '0;
      else                        w_new = 5'(w_cur - {4'b0, w_step});
    end else if (w_sum >= MAX6) begin
      w_new = 5'(MAXPOS);
      w_win = 1'b1;
    end else begin
      w_new = w_sum[4:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_gnt        <= '0;
      r_winner_vld <= 1'b0;
      r_winner_id  <= '0;
      for (int j = 0; j < NW; j++) r_pos[j] <= '0;
    end else begin
      r_gnt <= '0;
      if (start) begin
        r_state      <= S_RUN;
        r_ptr        <= '0;
        r_winner_vld <= 1'b0;
        for (int j = 0; j < NW; j++) r_pos[j] <= '0;
      end else if (r_state == S_RUN && w_any) begin
        r_gnt[w_idx]  <= 1'b1;
        r_pos[w_idx]  <= w_new;
        r_ptr         <= w_nxt;
        if (w_win) begin
          r_state      <= S_WIN;
          r_winner_vld <= 1'b1;
          r_winner_id  <= w_idx;
        end
      end
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_pos
    assign pos[5*g +: 5] = r_pos[g];
  end

  assign gnt        = r_gnt;
  assign running    = (r_state == S_RUN);
  assign winner_vld = r_winner_vld;
  assign winner_id  = r_winner_id;

endmodule

// File: tb/tb_worm_race_ctrl.sv
// Directed and randomized bench for worm_race_ctrl against a behavioural race model.
module tb_worm_race_ctrl;

  localparam int NW     = 4;
  localparam int MAXPOS = 15;

  logic            clk;
  logic            rstn;
  logic            start;
  logic [NW-1:0]   req;
  logic [2*NW-1:0] steps;
  logic [NW-1:0]   dir;
  logic [NW-1:0]   gnt;
  logic [5*NW-1:0] pos;
  logic            running;
  logic            winnerVld;
  logic [1:0]      winnerId;

  int nAsserts = 0;
  int nFails   = 0;

  int            mPos [NW];
  int            mPtr;
  bit            mRun;
  bit            mVld;
  int            mId;
  logic [NW-1:0] mGnt;

  worm_race_ctrl #(.NW(NW), .MAXPOS(MAXPOS)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .req        (req),
    .steps      (steps),
    .dir        (dir),
    .gnt        (gnt),
    .pos        (pos),
    .running    (running),
    .winner_vld (winnerVld),
    .winner_id  (winnerId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NW; i++) mPos[i] = 0;
    mPtr = 0;
    mRun = 0;
    mVld = 0;
    mId  = 0;
    mGnt = '0;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".gnt"}, 32'(gnt), 32'(mGnt));
    for (int i = 0; i < NW; i++)
      check($sformatf("%s.pos%0d", tag, i), 32'(pos[5*i +: 5]), 32'(mPos[i]));
    check({tag, ".running"}, 32'(running), 32'(mRun));
    check({tag, ".winner_vld"}, 32'(winnerVld), 32'(mVld));
    if (mVld) check({tag, ".winner_id"}, 32'(winnerId), 32'(mId));
  endtask

  // The model advances from the rules of the race: who is next in turn, how far they move.
  task automatic applyStimulus(input string tag, input logic s, input logic [NW-1:0] rq,
                               input logic [2*NW-1:0] st, input logic [NW-1:0] dr);
    int sel;
    int sz;
    int p;
    bit found;
    @(negedge clk);
    start = s;
    req   = rq;
    steps = st;
    dir   = dr;
    mGnt  = '0;
    if (s) begin
      for (int i = 0; i < NW; i++) mPos[i] = 0;
      mPtr = 0;
      mVld = 0;
      mRun = 1;
    end else if (mRun && rq != '0) begin
      found = 0;
      sel   = 0;
      for (int k = 0; k < NW; k++) begin
        if (!found && rq[(mPtr + k) % NW]) begin
          found = 1;
          sel   = (mPtr + k) % NW;
        end
      end
      sz = int'((st >> (2 * sel)) & 8'd3);
      if (dr[sel]) begin
        p = mPos[sel] - sz;
        if (p < 0) p = 0;
      end else begin
        p = mPos[sel] + sz;
        if (p >= MAXPOS) begin
          p    = MAXPOS;
          mVld = 1;
          mId  = sel;
          mRun = 0;
        end
      end
      mPos[sel] = p;
      mPtr      = (sel + 1) % NW;
      mGnt      = NW'(1 << sel);
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [NW-1:0] rrExp [5];
    rrExp[0] = 4'b0001; rrExp[1] = 4'b0010; rrExp[2] = 4'b0100;
    rrExp[3] = 4'b1000; rrExp[4] = 4'b0001;

    rstn  = 1'b0;
    start = 1'b0;
    req   = '0;
    steps = '0;
    dir   = '0;
    modelReset();
    #1;
    checkOutput("reset");
    @(negedge clk);
    rstn = 1'b1;

    applyStimulus("idle_req", 0, 4'b1111, 8'h55, 4'b0000);
    applyStimulus("start", 1, 4'b0000, 8'h00, 4'b0000);

    for (int i = 0; i < 5; i++) begin
      applyStimulus("rr", 0, 4'b1111, 8'h55, 4'b0000);
      check($sformatf("rr_seq%0d", i), 32'(gnt), 32'(rrExp[i]));
    end

    applyStimulus("w1_fwd", 0, 4'b0010, 8'h55, 4'b0000);
    applyStimulus("w1_back_sat", 0, 4'b0010, 8'hFF, 4'b0010);
    check("w1_floor", 32'(pos[9:5]), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus("w2_climb", 0, 4'b0100, 8'hFF, 4'b0000);
    applyStimulus("w2_to14", 0, 4'b0100, 8'h10, 4'b0000);
    check("w2_at14", 32'(pos[14:10]), 32'd14);
    applyStimulus("w2_win", 0, 4'b0100, 8'hFF, 4'b0000);
    check("win_id", 32'(winnerId), 32'd2);
    check("win_pos", 32'(pos[14:10]), 32'd15);

    for (int i = 0; i < 5; i++) applyStimulus("win_lock", 0, 4'b1111, 8'h55, 4'b0000);
    applyStimulus("restart", 1, 4'b1111, 8'h55, 4'b0000);
    applyStimulus("restart_g0", 0, 4'b1111, 8'h55, 4'b0000);

    applyStimulus("prio_pre", 0, 4'b0001, 8'h55, 4'b0000);
    applyStimulus("prio_start", 1, 4'b0001, 8'h55, 4'b0000);
    applyStimulus("prio_next", 0, 4'b0001, 8'h55, 4'b0000);

    applyStimulus("w3_a", 0, 4'b1000, 8'hC0, 4'b0000);
    applyStimulus("w3_b", 0, 4'b1000, 8'hC0, 4'b0000);
    applyStimulus("w3_c", 0, 4'b1000, 8'h40, 4'b0000);
    applyStimulus("w3_zero", 0, 4'b1000, 8'h00, 4'b0000);
    check("w3_stay7", 32'(pos[19:15]), 32'd7);
    applyStimulus("g0", 0, 4'b0001, 8'h55, 4'b0000);
    for (int i = 0; i < 3; i++) applyStimulus("partial", 0, 4'b1010, 8'h55, 4'b0000);

    // Drop reset between edges: outputs must clear without waiting for a clock.
    applyStimulus("pre_abort", 0, 4'b1111, 8'h55, 4'b0000);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [NW-1:0] rq;
      logic [NW-1:0] dr;
      rq = NW'($urandom);
      for (int j = 0; j < NW; j++) dr[j] = ($urandom_range(0, 3) == 0);
      applyStimulus("rand", ($urandom_range(0, 19) == 0), rq, 8'($urandom), dr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
